// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, FSM states and the default operand width.
package muldiv_seq_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return md_op_e'(op) inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return md_op_e'(op) inside {MD_MULT, MD_DIV};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the
// {acc, shreg} pair, purely combinational.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Remainder stays below the divisor, so the trial difference always fits in WIDTH bits
    always_comb begin
        sum        = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        shifted    = {acc, shreg[WIDTH-1]};
        diff       = shifted[WIDTH-1:0] - operand;
        acc_next   = sum[WIDTH:1];
        shreg_next = {sum[0], shreg[WIDTH-1:1]};
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                acc_next   = diff;
                shreg_next = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next   = shifted[WIDTH-1:0];
                shreg_next = {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO for the MIPS core.
// Optional mthi/mtlo write ports are enabled by defining MULDIV_MTHILO_EN.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
`ifdef MULDIV_MTHILO_EN
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc, shreg, opnd, acc_next, shreg_next;
    logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
    logic             is_div_q, neg_q, rem_neg_q, div0_pend_q, div0_q;
    logic [2*WIDTH-1:0] prod;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic             mt_hi, mt_lo;
    logic [WIDTH-1:0] mt_data;

`ifdef MULDIV_MTHILO_EN
    assign mt_hi   = wr_hi;
    assign mt_lo   = wr_lo;
    assign mt_data = wr_data;
`else
    assign mt_hi   = 1'b0;
    assign mt_lo   = 1'b0;
    assign mt_data = '0;
`endif

    // The loop always works on magnitudes; signs are reapplied in FIX
    assign a_neg = op_is_signed(op) & a[WIDTH-1];
    assign b_neg = op_is_signed(op) & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div_q),
        .acc        (acc),
        .shreg      (shreg),
        .operand    (opnd),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (count == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_FIX);
        stall = busy & hilo_rd & ~done;
        hi    = done ? res_hi : hi_q;
        lo    = done ? res_lo : lo_q;
        div0  = (done && is_div_q) ? div0_pend_q : div0_q;
    end

    // Divide-by-zero forces LO to all ones; HI comes back as the raw dividend
    always_comb begin
        prod   = neg_q ? -{acc, shreg} : {acc, shreg};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            res_hi = rem_neg_q ? -acc : acc;
            res_lo = div0_pend_q ? '1 : (neg_q ? -shreg : shreg);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            acc         <= '0;
            shreg       <= '0;
            opnd        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            div0_pend_q <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mt_hi) hi_q <= mt_data;
                    if (mt_lo) lo_q <= mt_data;
                    if (start) begin
                        is_div_q    <= op_is_div(op);
                        acc         <= '0;
                        shreg       <= op_is_div(op) ? a_mag : b_mag;
                        opnd        <= op_is_div(op) ? b_mag : a_mag;
                        neg_q       <= a_neg ^ b_neg;
                        rem_neg_q   <= a_neg;
                        div0_pend_q <= op_is_div(op) && (b == '0);
                        count       <= CW'(WIDTH - 1);
                        if (op_is_div(op) && (b != '0)) div0_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    shreg <= shreg_next;
                    count <= count - CW'(1);
                end
                ST_FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                    if (is_div_q) div0_q <= div0_pend_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with hand-computed results.
// Define MULDIV_MTHILO_EN to also exercise the mthi/mtlo write ports.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        hilo_rd = 1'b0;
    logic        busy, done, stall, div0;
    logic [31:0] hi, lo;
`ifdef MULDIV_MTHILO_EN
    logic        wr_hi = 1'b0, wr_lo = 1'b0;
    logic [31:0] wr_data = '0;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int lat, busy_cycles, stall_cycles, done_seen;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hilo_rd (hilo_rd),
`ifdef MULDIV_MTHILO_EN
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
`endif
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .div0    (div0),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and return in the done cycle (or after a timeout with lat=0)
    task automatic applyStimulus(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                                 input int rd_from, input int restart_at,
                                 output int lat_o, output int busy_o, output int stall_o);
        lat_o = 0;
        busy_o = 0;
        stall_o = 0;
        @(negedge clk);
        op = op_v;
        a = a_v;
        b = b_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            hilo_rd = (rd_from > 0) && (cyc >= rd_from);
            if (cyc == restart_at) begin
                start = 1'b1;
                op = MD_MULTU;
                a = 32'h55;
                b = 32'h77;
            end else begin
                start = 1'b0;
            end
            #1;
            if (busy) busy_o++;
            if (stall) stall_o++;
            if (done) begin
                lat_o = cyc;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #2;
        checkOutput("reset_flags", {60'd0, busy, done, stall, div0}, 64'd0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(MD_MULTU, 32'd7, 32'd6, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("multu_latency", lat, 33);
        checkOutput("multu_busy_cycles", busy_cycles, 33);
        checkOutput("multu_hi", hi, 32'h0);
        checkOutput("multu_lo", lo, 32'h2A);
        @(negedge clk);
        #1;
        checkOutput("multu_after_busy_done", {62'd0, busy, done}, 64'd0);
        checkOutput("multu_after_lo", lo, 32'h2A);

        applyStimulus(MD_MULT, 32'hFFFFFFFD, 32'd5, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFF1);

        applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);
        checkOutput("div_div0", div0, 0);

        applyStimulus(MD_DIVU, 32'd100, 32'd0, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("divu0_latency", lat, 33);
        checkOutput("divu0_lo", lo, 32'hFFFFFFFF);
        checkOutput("divu0_hi", hi, 32'h64);
        @(negedge clk);
        #1;
        checkOutput("divu0_div0_sticky", div0, 1);

        applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("div_ovf_lo", lo, 32'h80000000);
        checkOutput("div_ovf_hi", hi, 32'h0);
        checkOutput("div_ovf_div0_clear", div0, 0);

        applyStimulus(MD_DIV, 32'hFFFFFF9C, 32'd0, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("div0_signed_lo", lo, 32'hFFFFFFFF);
        checkOutput("div0_signed_hi", hi, 32'hFFFFFF9C);
        applyStimulus(MD_MULT, 32'd2, 32'd3, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("mult_keeps_lo", lo, 32'd6);
        @(negedge clk);
        #1;
        checkOutput("mult_keeps_div0", div0, 1);
        applyStimulus(MD_DIVU, 32'd10, 32'd3, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("divu_div0_cleared", div0, 0);

        hilo_rd = 1'b1;
        #1;
        checkOutput("idle_no_stall", stall, 0);
        hilo_rd = 1'b0;

        applyStimulus(MD_MULTU, 32'h00010000, 32'h00010000, 2, 10, lat, busy_cycles, stall_cycles);
        checkOutput("stall_latency", lat, 33);
        checkOutput("stall_cycles", stall_cycles, 31);
        checkOutput("stall_in_done", stall, 0);
        checkOutput("ignored_start_hi", hi, 32'h1);
        checkOutput("ignored_start_lo", lo, 32'h0);
        hilo_rd = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("ignored_start_not_busy", busy, 0);

        @(negedge clk);
        op = MD_MULTU;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);
        applyStimulus(MD_MULTU, 32'd3, 32'd3, 0, 0, lat, busy_cycles, stall_cycles);
        checkOutput("after_abort_lo", lo, 32'd9);
        checkOutput("after_abort_latency", lat, 33);

`ifdef MULDIV_MTHILO_EN
        @(negedge clk);
        @(negedge clk);
        wr_hi = 1'b1;
        wr_data = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0;
        #1;
        checkOutput("mthi_idle", hi, 32'h1234);
        op = MD_MULTU;
        a = 32'd2;
        b = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        wr_hi = 1'b1;
        wr_data = 32'hBEEF;
        @(negedge clk);
        wr_hi = 1'b0;
        #1;
        checkOutput("mthi_busy_dropped", hi, 32'h1234);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                done_seen = 1;
                break;
            end
        end
        checkOutput("mthi_busy_done", done_seen, 1);
        checkOutput("mthi_busy_result_hi", hi, 32'h0);
        checkOutput("mthi_busy_result_lo", lo, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
